// File: rtl/multi_operand_adder.sv
// multi_operand_adder
// Sums OPERANDS unsigned WIDTH-bit operands, accepted one per valid/ready
// handshake, into an exact WIDTH+CW-bit accumulator. The finished sum is
// presented on result/carry with out_valid until the consumer takes it.
//
// Optional feature: define MULTI_OPERAND_ADDER_CLEAR_EN to add the 'clear'
// input, which aborts a partially accumulated transaction.
module multi_operand_adder #(
  parameter int WIDTH    = 3,
  parameter int OPERANDS = 3,
  localparam int CW      = $clog2(OPERANDS),
  localparam int CNTW    = $clog2(OPERANDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    carry,
  output logic [CNTW-1:0]  count
);

  localparam int AW = WIDTH + CW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            accept;
  logic            clear_hit;

  // Handshake flags depend on state alone, so the consumer never sees a
  // combinational path from its own inputs back to in_ready/out_valid.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // The accumulator is zero in IDLE, so result/carry read 0 there for free.
  assign result = acc_q[WIDTH-1:0];
  assign carry  = acc_q[AW-1:WIDTH];
  assign count  = count_q;

`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
  // Abort only matters mid-transaction; IDLE has nothing to drop and DONE
  // owns a finished sum that must still be delivered.
  assign clear_hit = clear && (state_q == ACC);
`else
  assign clear_hit = 1'b0;
`endif

  // Next-state, accumulator and count update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (clear_hit) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end else if (accept) begin
          // Zero-extend to AW bits; AW is sized so the full sum never wraps.
          acc_d   = acc_q + AW'(operand);
          count_d = count_q + CNTW'(1);
          state_d = (count_q == CNTW'(OPERANDS - 1)) ? DONE : ACC;
        end
      end
      DONE: begin
        // out_valid is 1 throughout DONE, so out_ready alone completes it.
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        count_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multi_operand_adder.sv
// tb_multi_operand_adder
// Directed scoreboard bench. Stimulus pushes the hand-computed finished sum
// into a per-instance queue; a monitor pops and compares on every output
// handshake. Instance A is WIDTH=3/OPERANDS=3, instance B is WIDTH=4/
// OPERANDS=5. Define MULTI_OPERAND_ADDER_CLEAR_EN to include the clear test.
module tb_multi_operand_adder;

  typedef struct packed {
    logic [2:0] result;
    logic [1:0] carry;
    logic [1:0] count;
  } exp_a_t;

  typedef struct packed {
    logic [3:0] result;
    logic [2:0] carry;
    logic [2:0] count;
  } exp_b_t;

  logic clk = 1'b0;
  logic rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0] a_operand, a_result;
  logic [1:0] a_carry, a_count;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0] b_operand, b_result;
  logic [2:0] b_carry, b_count;

`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
  logic a_clear;
  logic b_clear;
`endif

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_operand_adder #(.WIDTH(3), .OPERANDS(3)) dut_a (
    .clk       (clk),
    .rst       (rst),
`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
    .clear     (a_clear),
`endif
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .operand   (a_operand),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .result    (a_result),
    .carry     (a_carry),
    .count     (a_count)
  );

  multi_operand_adder #(.WIDTH(4), .OPERANDS(5)) dut_b (
    .clk       (clk),
    .rst       (rst),
`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
    .clear     (b_clear),
`endif
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .operand   (b_operand),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .result    (b_result),
    .carry     (b_carry),
    .count     (b_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand on A, then 'gap' idle cycles.
  task automatic drive_a(input logic [2:0] op, input int gap);
    a_in_valid = 1'b1;
    a_operand  = op;
    tick();
    a_in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_a_idle(input string tag);
    check({tag, "_out_valid"}, a_out_valid, 0);
    check({tag, "_in_ready"},  a_in_ready,  1);
    check({tag, "_count"},     a_count,     0);
    check({tag, "_result"},    a_result,    0);
    check({tag, "_carry"},     a_carry,     0);
  endtask

  // Monitor for A: compare on each output handshake.
  always @(negedge clk) begin
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL a_unexpected_output: actual result=%0d carry=%0d, required no output", a_result, a_carry);
      end else begin
        exp_a_t e;
        e = q_a.pop_front();
        check("a_sb_result", a_result, e.result);
        check("a_sb_carry",  a_carry,  e.carry);
        check("a_sb_count",  a_count,  e.count);
      end
    end
  end

  // Monitor for B.
  always @(negedge clk) begin
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL b_unexpected_output: actual result=%0d carry=%0d, required no output", b_result, b_carry);
      end else begin
        exp_b_t e;
        e = q_b.pop_front();
        check("b_sb_result", b_result, e.result);
        check("b_sb_carry",  b_carry,  e.carry);
        check("b_sb_count",  b_count,  e.count);
      end
    end
  end

  // Watchdog: the sequence is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_operand   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_operand   = '0;
    b_out_ready = 1'b1;
`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
    a_clear     = 1'b0;
    b_clear     = 1'b0;
`endif
    tick();
    tick();
    check_a_idle("reset");
    check("reset_b_in_ready", b_in_ready, 1);
    check("reset_b_out_valid", b_out_valid, 0);
    rst = 1'b0;
    tick();

    // 1,2,3 back to back -> 6 = 0b00_110.
    q_a.push_back('{result: 3'b110, carry: 2'b00, count: 2'd3});
    drive_a(3'd1, 0);
    drive_a(3'd2, 0);
    drive_a(3'd3, 0);
    check("b2b_latency_out_valid", a_out_valid, 1);
    check("b2b_in_ready_done", a_in_ready, 0);
    tick();
    check_a_idle("b2b_after");

    // 5,2,1 with two idle cycles between -> 8 = 0b01_000.
    q_a.push_back('{result: 3'b000, carry: 2'b01, count: 2'd3});
    check("gap_count0", a_count, 0);
    drive_a(3'd5, 2);
    check("gap_count1", a_count, 1);
    check("gap_partial1", a_result, 5);
    drive_a(3'd2, 2);
    check("gap_count2", a_count, 2);
    check("gap_partial2", a_result, 7);
    check("gap_state_acc_out_valid", a_out_valid, 0);
    drive_a(3'd1, 0);
    check("gap_count3", a_count, 3);
    check("gap_out_valid", a_out_valid, 1);
    tick();
    check_a_idle("gap_after");

    // 7,7,7 with back-pressure -> 21 = 0b10_101; DONE ignores inputs.
    a_out_ready = 1'b0;
    q_a.push_back('{result: 3'b101, carry: 2'b10, count: 2'd3});
    drive_a(3'd7, 0);
    drive_a(3'd7, 0);
    drive_a(3'd7, 0);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_operand  = 3'(i + 2);
      check("hold_out_valid", a_out_valid, 1);
      check("hold_in_ready",  a_in_ready,  0);
      check("hold_result",    a_result,    3'b101);
      check("hold_carry",     a_carry,     2'b10);
      check("hold_count",     a_count,     3);
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check_a_idle("hold_release");

    // 3,4 then reset together with a valid operand: partial sum discarded.
    drive_a(3'd3, 0);
    drive_a(3'd4, 0);
    check("abort_partial_count", a_count, 2);
    check("abort_partial_result", a_result, 7);
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_operand  = 3'd5;
    tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    check_a_idle("abort_rst");
    q_a.push_back('{result: 3'b011, carry: 2'b00, count: 2'd3});
    drive_a(3'd1, 0);
    drive_a(3'd1, 0);
    drive_a(3'd1, 0);
    tick();
    check_a_idle("abort_fresh_after");

`ifdef MULTI_OPERAND_ADDER_CLEAR_EN
    // 6,6 then clear with operand 6 valid: dropped, back to IDLE.
    drive_a(3'd6, 0);
    drive_a(3'd6, 0);
    a_clear    = 1'b1;
    a_in_valid = 1'b1;
    a_operand  = 3'd6;
    tick();
    a_clear    = 1'b0;
    a_in_valid = 1'b0;
    check_a_idle("clear_acc");
    // 2,2,2 -> 6; clear asserted on the first operand is ignored in IDLE.
    q_a.push_back('{result: 3'b110, carry: 2'b00, count: 2'd3});
    a_clear = 1'b1;
    drive_a(3'd2, 0);
    a_clear = 1'b0;
    check("clear_idle_ignored_count", a_count, 1);
    drive_a(3'd2, 0);
    drive_a(3'd2, 0);
    tick();
    check_a_idle("clear_fresh_after");
`endif

    // Instance B: five 15s -> 75 = 0b100_1011.
    q_b.push_back('{result: 4'b1011, carry: 3'b100, count: 3'd5});
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_operand  = 4'd15;
      tick();
    end
    b_in_valid = 1'b0;
    check("b_out_valid", b_out_valid, 1);
    check("b_count5", b_count, 5);
    tick();
    check("b_idle_out_valid", b_out_valid, 0);
    check("b_idle_result", b_result, 0);

    tick();
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
